// File: rtl/zone_irrigation_scheduler_if.sv
// Signal bundle between the irrigation scheduler and its surroundings
// (zone request logic, ESP32 turbidity sensor, valve drivers).
//
// Sensor handshake: enable_esp is a held request. It stays high until the first
// cycle in which ready_from_esp is high while enable_esp is high. turbidez is
// taken in exactly that cycle. ready_from_esp seen while enable_esp is low is
// ignored.
interface zone_irrigation_scheduler_if #(
  parameter int NZONES = 4
);
  localparam int ZW = $clog2(NZONES);

  logic [NZONES-1:0] zone_req;
  logic [11:0]       turbidez;
  logic              ready_from_esp;
  logic              enable_esp;
  logic [NZONES-1:0] valve;
  logic [ZW-1:0]     active_zone;
  logic              busy;
  logic              sensor_fault;
  logic [2:0]        state_dbg;

  // master: the scheduler
  modport master (
    input  zone_req, turbidez, ready_from_esp,
    output enable_esp, valve, active_zone, busy, sensor_fault, state_dbg
  );

  // slave: request logic, sensor and valve drivers
  modport slave (
    output zone_req, turbidez, ready_from_esp,
    input  enable_esp, valve, active_zone, busy, sensor_fault, state_dbg
  );
endinterface

// File: rtl/zone_irrigation_scheduler.sv
// Round-robin irrigation scheduler: one shared turbidity sensor, one water line, NZONES valves.
// Optional build macro ZONE_ABORT_EN: end watering early when the active zone drops its request.
module zone_irrigation_scheduler #(
  parameter int NZONES         = 4,
  parameter int TH_HIGH        = 12,
  parameter int TH_LOW         = 8,
  parameter int CYCLES_LONG    = 250000000,
  parameter int CYCLES_SHORT   = 125000000,
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int GAP_CYCLES     = 2500000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  zone_irrigation_scheduler_if.master   bus
);
  localparam int ZW = $clog2(NZONES);

  localparam logic [11:0] TH_HIGH_V    = 12'(TH_HIGH);
  localparam logic [11:0] TH_LOW_V     = 12'(TH_LOW);
  localparam logic [31:0] LONG_V       = 32'(CYCLES_LONG);
  localparam logic [31:0] SHORT_V      = 32'(CYCLES_SHORT);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_ESP = 3'd1,
    S_DECIDE  = 3'd2,
    S_WATER   = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  state_t            state;
  logic [31:0]       timer;
  logic [31:0]       duration;
  logic [11:0]       sample;
  logic [ZW-1:0]     last_grant;
  logic [ZW-1:0]     active_zone;
  logic              enable_esp;
  logic              busy;
  logic              sensor_fault;
  logic [NZONES-1:0] valve;

  logic [ZW-1:0]     grant;
  logic              found;
  int                idx;
  logic [31:0]       dur_sel;
  logic [NZONES-1:0] zone_onehot;
  logic              water_done;

  // First requester strictly after the previous grant, wrapping around.
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NZONES; i++) begin
      idx = (int'(last_grant) + 1 + i) % NZONES;
      if (!found && bus.zone_req[idx]) begin
        grant = ZW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    if (sample >= TH_HIGH_V)      dur_sel = LONG_V;
    else if (sample >= TH_LOW_V)  dur_sel = SHORT_V;
    else                          dur_sel = '0;
  end

  always_comb begin
    zone_onehot              = '0;
    zone_onehot[active_zone] = 1'b1;
  end

`ifdef ZONE_ABORT_EN
  assign water_done = (timer == duration - 32'd1) || !bus.zone_req[active_zone];
`else
  assign water_done = (timer == duration - 32'd1);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      duration     <= '0;
      sample       <= '0;
      last_grant   <= ZW'(NZONES - 1);
      active_zone  <= '0;
      enable_esp   <= 1'b0;
      busy         <= 1'b0;
      sensor_fault <= 1'b0;
      valve        <= '0;
    end else begin
      sensor_fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.zone_req != '0) begin
            active_zone <= grant;
            busy        <= 1'b1;
            enable_esp  <= 1'b1;
            timer       <= '0;
            state       <= S_REQ_ESP;
          end
        end
        S_REQ_ESP: begin
          timer <= timer + 32'd1;
          // A sample arriving in the timeout cycle is still accepted.
          if (bus.ready_from_esp) begin
            sample     <= bus.turbidez;
            enable_esp <= 1'b0;
            state      <= S_DECIDE;
          end else if (timer == TIMEOUT_LAST) begin
            enable_esp   <= 1'b0;
            sensor_fault <= 1'b1;
            timer        <= '0;
            state        <= S_GAP;
          end
        end
        S_DECIDE: begin
          timer    <= '0;
          duration <= dur_sel;
          if (dur_sel == '0) begin
            state <= S_GAP;
          end else begin
            valve <= zone_onehot;
            state <= S_WATER;
          end
        end
        S_WATER: begin
          timer <= timer + 32'd1;
          if (water_done) begin
            valve <= '0;
            timer <= '0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          timer <= timer + 32'd1;
          if (timer == GAP_LAST) begin
            timer      <= '0;
            last_grant <= active_zone;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          valve      <= '0;
          enable_esp <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable_esp   = enable_esp;
  assign bus.valve        = valve;
  assign bus.active_zone  = active_zone;
  assign bus.busy         = busy;
  assign bus.sensor_fault = sensor_fault;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_zone_irrigation_scheduler.sv
// Directed bench for zone_irrigation_scheduler with short timing parameters.
module tb_zone_irrigation_scheduler;
  localparam int NZ       = 4;
  localparam int C_LONG   = 20;
  localparam int C_SHORT  = 10;
  localparam int C_TMO    = 16;
  localparam int C_GAP    = 4;

  localparam logic [31:0] ST_IDLE   = 32'd0;
  localparam logic [31:0] ST_DECIDE = 32'd2;
  localparam logic [31:0] ST_GAP    = 32'd4;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   fault_pulses;
  int   excl_err;

  zone_irrigation_scheduler_if #(.NZONES(NZ)) bus ();

  zone_irrigation_scheduler #(
    .NZONES(NZ), .TH_HIGH(12), .TH_LOW(8),
    .CYCLES_LONG(C_LONG), .CYCLES_SHORT(C_SHORT),
    .TIMEOUT_CYCLES(C_TMO), .GAP_CYCLES(C_GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // background monitor: fault pulses and valve exclusivity
  initial begin
    fault_pulses = 0;
    excl_err     = 0;
  end
  always @(negedge clk) begin
    if (bus.sensor_fault === 1'b1) fault_pulses++;
    if (!$onehot0(bus.valve) || (bus.valve != '0 && bus.enable_esp)) excl_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_enable(input string tag);
    int guard;
    guard = 0;
    while (bus.enable_esp !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_enable"}, 32'(bus.enable_esp), 32'd1);
  endtask

  task automatic gap_phase(input string tag);
    int gap;
    int guard;
    logic side_err;
    gap = 0; guard = 0; side_err = 1'b0;
    while (32'(bus.state_dbg) == ST_GAP && guard < 50) begin
      gap++;
      if (bus.valve != '0 || bus.enable_esp || !bus.busy) side_err = 1'b1;
      @(negedge clk);
      guard++;
    end
    check({tag, "_gap_len"}, 32'(gap), 32'(C_GAP));
    check({tag, "_gap_outputs"}, 32'(side_err), 32'd0);
    check({tag, "_after_gap_state"}, 32'(bus.state_dbg), ST_IDLE);
  endtask

  // driver: one full grant from enable rise to return to IDLE
  task automatic service(input int delay, input logic [11:0] turb, input logic [3:0] exp_valve,
                         input int exp_dur, input int exp_zone, input string tag);
    int en_cnt;
    int run;
    int guard;
    wait_enable(tag);
    check({tag, "_zone"}, 32'(bus.active_zone), 32'(exp_zone));
    en_cnt = 1;
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      if (bus.enable_esp) en_cnt++;
    end
    bus.ready_from_esp = 1'b1;
    bus.turbidez       = turb;
    @(negedge clk);
    bus.ready_from_esp = 1'b0;
    bus.turbidez       = '0;
    check({tag, "_enable_cycles"}, 32'(en_cnt), 32'(delay));
    check({tag, "_decide_state"}, 32'(bus.state_dbg), ST_DECIDE);
    check({tag, "_enable_off"}, 32'(bus.enable_esp), 32'd0);
    @(negedge clk);
    run = 0; guard = 0;
    if (exp_valve != 4'b0000) begin
      while (bus.valve === exp_valve && guard < 200) begin
        run++;
        @(negedge clk);
        guard++;
      end
    end
    check({tag, "_valve_cycles"}, 32'(run), 32'(exp_dur));
    check({tag, "_valve_closed"}, 32'(bus.valve), 32'd0);
    check({tag, "_gap_state"}, 32'(bus.state_dbg), ST_GAP);
    gap_phase(tag);
  endtask

  initial begin
    int en_cnt;
    int guard;
    int run;
    int f0;
    int exp_run;
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    bus.zone_req       = '0;
    bus.turbidez       = '0;
    bus.ready_from_esp = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_valve", 32'(bus.valve), 32'd0);
    check("rst_enable", 32'(bus.enable_esp), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_zone", 32'(bus.active_zone), 32'd0);
    check("rst_fault", 32'(bus.sensor_fault), 32'd0);
    check("rst_state", 32'(bus.state_dbg), ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;

    // long watering for zone 0, sample after 3 cycles
    bus.zone_req = 4'b0001;
    service(3, 12'd12, 4'b0001, C_LONG, 0, "t1");
    bus.zone_req = 4'b0000;
    repeat (2) @(negedge clk);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);
    // ready outside REQ_ESP is ignored
    bus.ready_from_esp = 1'b1;
    bus.turbidez       = 12'd15;
    @(negedge clk);
    bus.ready_from_esp = 1'b0;
    @(negedge clk);
    check("stray_ready_state", 32'(bus.state_dbg), ST_IDLE);
    check("stray_ready_enable", 32'(bus.enable_esp), 32'd0);

    // short watering for zone 2, then a below-threshold sample
    bus.zone_req = 4'b0100;
    service(1, 12'd8, 4'b0100, C_SHORT, 2, "t2a");
    service(2, 12'd7, 4'b0000, 0, 2, "t2b");
    bus.zone_req = 4'b0000;

    // fresh start, round robin over zones 0,1,3
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.zone_req = 4'b1011;
    service(1, 12'd15, 4'b0001, C_LONG, 0, "rr0");
    service(1, 12'd15, 4'b0010, C_LONG, 1, "rr1");
    service(1, 12'd15, 4'b1000, C_LONG, 3, "rr2");
    service(1, 12'd15, 4'b0001, C_LONG, 0, "rr3");
    service(1, 12'd15, 4'b0010, C_LONG, 1, "rr4");
    service(1, 12'd15, 4'b1000, C_LONG, 3, "rr5");
    bus.zone_req = 4'b0000;

    // sensor timeout on zone 1, then retry
    f0 = fault_pulses;
    bus.zone_req = 4'b0010;
    wait_enable("tmo");
    check("tmo_zone", 32'(bus.active_zone), 32'd1);
    en_cnt = 1; guard = 0;
    while (bus.enable_esp === 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (bus.enable_esp) en_cnt++;
    end
    check("tmo_enable_cycles", 32'(en_cnt), 32'(C_TMO));
    check("tmo_fault_pulse", 32'(bus.sensor_fault), 32'd1);
    check("tmo_valve", 32'(bus.valve), 32'd0);
    gap_phase("tmo");
    service(1, 12'd0, 4'b0000, 0, 1, "tmo_retry");
    bus.zone_req = 4'b0000;
    check("tmo_fault_count", 32'(fault_pulses - f0), 32'd1);

    // asynchronous reset mid-watering
    bus.zone_req = 4'b0001;
    wait_enable("arst");
    check("arst_zone", 32'(bus.active_zone), 32'd0);
    bus.ready_from_esp = 1'b1;
    bus.turbidez       = 12'd12;
    @(negedge clk);
    bus.ready_from_esp = 1'b0;
    @(negedge clk);
    check("arst_valve_open", 32'(bus.valve), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valve_async", 32'(bus.valve), 32'd0);
    check("arst_busy_async", 32'(bus.busy), 32'd0);
    check("arst_state_async", 32'(bus.state_dbg), ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    bus.zone_req = 4'b1111;
    wait_enable("arst_after");
    check("arst_first_zone", 32'(bus.active_zone), 32'd0);

    // request withdrawn in watering cycle 5
    bus.zone_req       = 4'b0001;
    bus.ready_from_esp = 1'b1;
    bus.turbidez       = 12'd12;
    @(negedge clk);
    bus.ready_from_esp = 1'b0;
    bus.turbidez       = '0;
    @(negedge clk);
    run = 0; guard = 0;
    while (bus.valve === 4'b0001 && guard < 100) begin
      run++;
      if (run == 5) bus.zone_req = 4'b0000;
      @(negedge clk);
      guard++;
    end
`ifdef ZONE_ABORT_EN
    exp_run = 5;
`else
    exp_run = C_LONG;
`endif
    check("drop_valve_cycles", 32'(run), 32'(exp_run));
    check("drop_gap_state", 32'(bus.state_dbg), ST_GAP);
    gap_phase("drop");
    @(negedge clk);
    check("drop_final_busy", 32'(bus.busy), 32'd0);

    check("valve_exclusive", 32'(excl_err), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/zone_irrigation_scheduler.md
Name: zone_irrigation_scheduler

Overview:
- Round-robin scheduler that shares one ESP32 turbidity sensor and one water line among NZONES irrigation zones.
- For each granted zone it:
  - runs one sensor handshake (enable_esp / ready_from_esp);
  - classifies the turbidity sample into a watering duration;
  - opens only that zone's valve for that duration;
  - then inserts a rest gap.
- Sits between the zone request logic (field switches or soil-moisture flags) and the valve LED/driver outputs. It replaces per-zone sequencing.

Parameters:
- NZONES, 4, number of zones (2..8); ZW = $clog2(NZONES).
- TH_HIGH, 12, turbidity at or above this value selects the long watering time.
- TH_LOW, 8, turbidity at or above this value (and below TH_HIGH) selects the short time.
- CYCLES_LONG, 250000000, valve-open cycles for the long time (10 s at 25 MHz).
- CYCLES_SHORT, 125000000, valve-open cycles for the short time (5 s at 25 MHz).
- TIMEOUT_CYCLES, 25000000, maximum wait for ready_from_esp (1 s).
- GAP_CYCLES, 2500000, all-off rest between zones (0.1 s); must be ≥1.

Ports:
- clk  in  1  system clock, 25 MHz
- reset_n  in  1  reset, asynchronous, active-low
- zone_req  in  NZONES  level request per zone, bit i = zone i wants water
- turbidez  in  12  turbidity sample from ESP32, unsigned
- ready_from_esp  in  1  sample-valid flag from ESP32
- enable_esp  out  1  sensor enable
- valve  out  NZONES  valve drives, one-hot or zero, active-high
- active_zone  out  ZW  zone currently granted
- busy  out  1  high in any state other than IDLE
- sensor_fault  out  1  one-cycle pulse when the sensor handshake times out

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; enable_esp=0, valve=0, active_zone=0, busy=0, sensor_fault=0; timer=0; last_grant=NZONES-1, so zone 0 wins first.
- All outputs are registered. The timer is 32-bit unsigned.
- IDLE:
  - If zone_req≠0, grant the first set bit searching upward from last_grant+1 with wrap-around.
  - Next cycle: active_zone=grant, busy=1, enable_esp=1, timer=0, state=REQ_ESP.
  - If zone_req=0, stay in IDLE.
- REQ_ESP:
  - enable_esp held high; timer increments each cycle.
  - If ready_from_esp=1: capture turbidez in that cycle, enable_esp=0 next cycle, go to DECIDE.
  - Else, if timer==TIMEOUT_CYCLES-1: enable_esp=0, sensor_fault=1 for one cycle, valve stays closed, go to GAP.
  - If ready and the timeout coincide, ready wins.
- DECIDE (exactly 1 cycle):
  - duration = CYCLES_LONG if sample≥TH_HIGH; CYCLES_SHORT if TH_LOW≤sample<TH_HIGH; otherwise 0.
  - duration=0: go to GAP with the valve never opened.
  - Otherwise: valve[active_zone]=1 next cycle, timer=0, go to WATER.
- WATER:
  - valve is high for exactly `duration` consecutive cycles.
  - When timer==duration-1: valve=0 next cycle, go to GAP.
  - zone_req changes are ignored (but see the optional feature).
- GAP:
  - All outputs low except busy and active_zone, for GAP_CYCLES cycles.
  - Then last_grant=active_zone and state=IDLE.
- ready_from_esp outside REQ_ESP is ignored.
- turbidez is sampled only in the ready cycle.
- At most one valve bit is ever set; valve and enable_esp are never high together.
- A zone still requesting after its service is re-queued behind the other requesters (fairness). A lone requester is re-served after GAP.
- Asserting reset_n=0 mid-WATER closes the valve immediately (asynchronously).

Optional Feature:
- Macro: ZONE_ABORT_EN.
- Defined: if zone_req[active_zone] is 0 in any WATER cycle, valve=0 next cycle and state goes to GAP (the normal gap still applies).
- Undefined: a watering cycle always runs its full duration regardless of zone_req.

Test Plan:
Bench parameters: CYCLES_LONG=20, CYCLES_SHORT=10, TIMEOUT_CYCLES=16, GAP_CYCLES=4, NZONES=4.
- zone_req=0001 from reset; ready pulse with turbidez=12 after 3 cycles → enable_esp high 3 cycles, then valve=0001 for exactly 20 cycles, 4-cycle gap, busy low afterwards once req is dropped.
- zone_req=0100, turbidez=8 → valve=0100 for exactly 10 cycles; turbidez=7 → valve stays 0000, straight to GAP.
- zone_req=1011 held constant, ready immediate, turbidez=15 → service order 0,1,3,0,1,3; valve is never multi-hot.
- zone_req=0010, no ready → sensor_fault pulses once in cycle 16 of REQ_ESP, valve stays 0, GAP, then the zone retries.
- reset_n pulled low during WATER → valve=0 without waiting for a clock edge; after release, zone 0 is served first.
- ZONE_ABORT_EN defined: drop zone_req in WATER cycle 5 of 20 → valve closes the next cycle, 4-cycle gap follows. Undefined: valve stays open the full 20 cycles.
